// File: rtl/stream_pkg.sv
// Shared definitions for the user-side stream merging stages.
package stream_pkg;

    // Width of one BFT payload word as delivered by leaf_interface.
    localparam int DEFAULT_PAYLOAD_BITS = 32;

    // A single tag bit is enough to name which of the two ports delivered a word.
    localparam int SRC_BITS = 1;

    // Width of a word as stored in the output buffer: source tag above payload.
    localparam int TAGGED_BITS = DEFAULT_PAYLOAD_BITS + SRC_BITS;

    // Source tag values.
    localparam logic SRC_PORT1 = 1'b0;
    localparam logic SRC_PORT2 = 1'b1;

endpackage

// File: rtl/stream_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is always presented on dout.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module stream_fifo_fwft #(
    parameter int WIDTH      = 33,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_BITS:0] wr_ptr;
    logic [DEPTH_BITS:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                     (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[DEPTH_BITS-1:0]];

    // Advance the read and write pointers on accepted pops and pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr[DEPTH_BITS-1:0]] <= din;
        end
    end

endmodule

// File: rtl/stream_merge2.sv
// Merges the two leaf_interface output streams into one tagged, buffered
// stream using round-robin arbitration, with per-port accepted-word counters.
module stream_merge2
    import stream_pkg::*;
#(
    parameter int PAYLOAD_BITS    = DEFAULT_PAYLOAD_BITS,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int CNT_BITS        = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [PAYLOAD_BITS-1:0] din1,
    input  logic                    val_in1,
    output logic                    ready_upward1,
    input  logic [PAYLOAD_BITS-1:0] din2,
    input  logic                    val_in2,
    output logic                    ready_upward2,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    src_out,
    output logic                    val_out,
    input  logic                    ready_downward,
    output logic [CNT_BITS-1:0]     cnt1,
    output logic [CNT_BITS-1:0]     cnt2
);

    localparam int WORD_BITS = PAYLOAD_BITS + SRC_BITS;

    logic                 prio;
    logic                 full;
    logic                 empty;
    logic                 accept1;
    logic                 accept2;
    logic [WORD_BITS-1:0] fifo_din;
    logic [WORD_BITS-1:0] fifo_dout;

    // A port is offered the slot when the buffer has room and either it holds
    // priority or the other port has nothing to send; this grants at most one.
    assign ready_upward1 = !full && (prio == SRC_PORT1 || !val_in2);
    assign ready_upward2 = !full && (prio == SRC_PORT2 || !val_in1);
    assign accept1       = val_in1 && ready_upward1;
    assign accept2       = val_in2 && ready_upward2;
    assign fifo_din      = accept2 ? {SRC_PORT2, din2} : {SRC_PORT1, din1};

    assign val_out = !empty;
    assign src_out = fifo_dout[WORD_BITS-1];
    assign dout    = fifo_dout[PAYLOAD_BITS-1:0];

    // After serving a port, hand priority to the other one so that two busy
    // ports alternate while a lone busy port still streams every cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio <= SRC_PORT1;
        end else if (accept1) begin
            prio <= SRC_PORT2;
        end else if (accept2) begin
            prio <= SRC_PORT1;
        end
    end

    // Count accepted words per port; the counters wrap rather than saturate.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (accept1) begin
                cnt1 <= cnt1 + CNT_BITS'(1);
            end
            if (accept2) begin
                cnt2 <= cnt2 + CNT_BITS'(1);
            end
        end
    end

    stream_fifo_fwft #(
        .WIDTH      (WORD_BITS),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (accept1 || accept2),
        .din   (fifo_din),
        .full  (full),
        .pop   (ready_downward),
        .dout  (fifo_dout),
        .empty (empty)
    );

endmodule

// File: tb/tb_stream_merge2.sv
// Self-checking bench for stream_merge2: a queue-based reference model is
// compared against the DUT on every falling edge, with directed scenarios
// adding hand-computed expectations.
module tb_stream_merge2;

    localparam int PW    = 32;
    localparam int DB    = 2;
    localparam int CB    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [PW-1:0] din1;
    logic          val_in1;
    logic          ready_upward1;
    logic [PW-1:0] din2;
    logic          val_in2;
    logic          ready_upward2;
    logic [PW-1:0] dout;
    logic          src_out;
    logic          val_out;
    logic          ready_downward;
    logic [CB-1:0] cnt1;
    logic [CB-1:0] cnt2;

    typedef struct {
        logic          src;
        logic [PW-1:0] data;
    } word_t;

    word_t model_q[$];
    word_t out_log[$];
    word_t tmp_word;
    logic  model_prio = 1'b0;
    int    model_cnt1 = 0;
    int    model_cnt2 = 0;
    logic  exp_val;
    logic  exp_full;
    logic  exp_r1;
    logic  exp_r2;

    int errors = 0;
    int checks = 0;

    stream_merge2 #(
        .PAYLOAD_BITS    (PW),
        .FIFO_DEPTH_BITS (DB),
        .CNT_BITS        (CB)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .din1           (din1),
        .val_in1        (val_in1),
        .ready_upward1  (ready_upward1),
        .din2           (din2),
        .val_in2        (val_in2),
        .ready_upward2  (ready_upward2),
        .dout           (dout),
        .src_out        (src_out),
        .val_out        (val_out),
        .ready_downward (ready_downward),
        .cnt1           (cnt1),
        .cnt2           (cnt2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v1, input logic [PW-1:0] d1,
                                 input logic v2, input logic [PW-1:0] d2,
                                 input logic rd);
        val_in1        = v1;
        din1           = d1;
        val_in2        = v2;
        din2           = d2;
        ready_downward = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
    endtask

    // Reference model: checks outputs held over the current cycle, then
    // advances to the state the next rising edge must produce.
    always @(negedge clk) begin
        if (!resetn) begin
            checkOutput("rst val_out", val_out, 1'b0);
            checkOutput("rst dout", dout, 0);
            checkOutput("rst src_out", src_out, 1'b0);
            checkOutput("rst cnt1", cnt1, 0);
            checkOutput("rst cnt2", cnt2, 0);
            model_q.delete();
            model_prio = 1'b0;
            model_cnt1 = 0;
            model_cnt2 = 0;
        end else begin
            exp_val  = (model_q.size() != 0);
            exp_full = (model_q.size() == DEPTH);
            exp_r1   = !exp_full && (!model_prio || !val_in2);
            exp_r2   = !exp_full && (model_prio || !val_in1);
            checkOutput("val_out", val_out, exp_val);
            if (exp_val) begin
                checkOutput("dout", dout, model_q[0].data);
                checkOutput("src_out", src_out, model_q[0].src);
            end
            checkOutput("cnt1", cnt1, model_cnt1 % 16);
            checkOutput("cnt2", cnt2, model_cnt2 % 16);
            checkOutput("ready_upward1", ready_upward1, exp_r1);
            checkOutput("ready_upward2", ready_upward2, exp_r2);
            if (exp_val && ready_downward) begin
                out_log.push_back(model_q[0]);
                void'(model_q.pop_front());
            end
            if (val_in1 && exp_r1) begin
                tmp_word.src  = 1'b0;
                tmp_word.data = din1;
                model_q.push_back(tmp_word);
                model_cnt1++;
                model_prio = 1'b1;
            end else if (val_in2 && exp_r2) begin
                tmp_word.src  = 1'b1;
                tmp_word.data = din2;
                model_q.push_back(tmp_word);
                model_cnt2++;
                model_prio = 1'b0;
            end
        end
    end

    initial begin
        int            i1;
        int            i2;
        int            accepted;
        logic          a1;
        logic          a2;
        logic [PW-1:0] d;
        int            exp_order [8];

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        #1 resetn = 1'b0;
        #1;
        checkOutput("init val_out", val_out, 1'b0);
        checkOutput("init cnt1", cnt1, 0);
        applyReset();

        // Single word from port 1 appears one cycle after acceptance.
        $display("[TB] single word");
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b1);
        #1 checkOutput("t1 ready_upward1", ready_upward1, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        #1;
        checkOutput("t1 dout", dout, 32'hDEADBEEF);
        checkOutput("t1 src_out", src_out, 1'b0);
        checkOutput("t1 val_out", val_out, 1'b1);
        checkOutput("t1 cnt1", cnt1, 1);
        step();

        // Both ports busy: grants alternate starting with port 1.
        $display("[TB] alternation");
        applyReset();
        out_log.delete();
        i1 = 1;
        i2 = 101;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(i1 <= 4, PW'(i1), i2 <= 104, PW'(i2), 1'b1);
            #1;
            a1 = val_in1 && ready_upward1;
            a2 = val_in2 && ready_upward2;
            step();
            if (a1) i1++;
            if (a2) i2++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (3) step();
        exp_order = '{1, 101, 2, 102, 3, 103, 4, 104};
        checkOutput("t2 words out", out_log.size(), 8);
        for (int k = 0; k < 8 && k < out_log.size(); k++) begin
            checkOutput("t2 order data", out_log[k].data, exp_order[k]);
            checkOutput("t2 order src", out_log[k].src, k % 2);
        end
        checkOutput("t2 cnt1", cnt1, 4);
        checkOutput("t2 cnt2", cnt2, 4);

        // Stalled consumer: port 2 fills the buffer, one pop frees one slot.
        $display("[TB] full and backpressure");
        applyReset();
        out_log.delete();
        accepted = 0;
        d = 200;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, '0, 1'b1, d, 1'b0);
            #1 a2 = ready_upward2;
            step();
            if (a2) begin
                accepted++;
                d++;
            end
        end
        applyStimulus(1'b0, '0, 1'b1, d, 1'b0);
        #1;
        checkOutput("t3 accepted", accepted, 4);
        checkOutput("t3 full ready2", ready_upward2, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, d, 1'b1);
        #1 checkOutput("t3 pop-cycle ready2", ready_upward2, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b1, d, 1'b0);
        #1 checkOutput("t3 after-pop ready2", ready_upward2, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (6) step();
        checkOutput("t3 words out", out_log.size(), 5);
        for (int k = 0; k < 5 && k < out_log.size(); k++) begin
            checkOutput("t3 data", out_log[k].data, 200 + k);
        end

        // Steady push and pop at occupancy 2.
        $display("[TB] push and pop together");
        applyReset();
        out_log.delete();
        d = 1;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, d, 1'b0, '0, 1'b0);
            step();
            d++;
        end
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, d, 1'b0, '0, 1'b1);
            step();
            d++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("t4 val_out", val_out, 1'b1);
        checkOutput("t4 popped", out_log.size(), 10);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (4) step();
        checkOutput("t4 total", out_log.size(), 12);
        for (int k = 0; k < 12 && k < out_log.size(); k++) begin
            checkOutput("t4 data", out_log[k].data, k + 1);
        end

        // Counter wraps modulo 2^4.
        $display("[TB] counter wrap");
        applyReset();
        for (int c = 0; c < 17; c++) begin
            applyStimulus(1'b1, PW'(c), 1'b0, '0, 1'b1);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        #1;
        checkOutput("t5 cnt1", cnt1, 1);
        checkOutput("t5 cnt2", cnt2, 0);
        repeat (3) step();

        // Asynchronous reset with words buffered.
        $display("[TB] mid-stream reset");
        applyReset();
        out_log.delete();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, PW'(300 + c), 1'b0, '0, 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        #1 checkOutput("t6 buffered val_out", val_out, 1'b1);
        resetn = 1'b0;
        #1;
        checkOutput("t6 async val_out", val_out, 1'b0);
        checkOutput("t6 async cnt1", cnt1, 0);
        checkOutput("t6 async dout", dout, 0);
        repeat (2) step();
        resetn = 1'b1;
        #1;
        checkOutput("t6 release val_out", val_out, 1'b0);
        checkOutput("t6 release cnt1", cnt1, 0);
        applyStimulus(1'b1, 32'h55, 1'b0, '0, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        #1;
        checkOutput("t6 new dout", dout, 32'h55);
        checkOutput("t6 new val_out", val_out, 1'b1);
        repeat (2) step();
        checkOutput("t6 words out", out_log.size(), 1);
        if (out_log.size() > 0) begin
            checkOutput("t6 first word", out_log[0].data, 32'h55);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
